// File: rtl/bootrom_axil_frontend_if.sv
// AXI4-Lite channel bundle between the crossbar and the boot ROM front-end.
// Read channels carry address/data; write channels carry handshakes only.
interface bootrom_axil_frontend_if;
   logic        ar_valid_i;
   logic        ar_ready_o;
   logic [63:0] ar_addr_i;
   logic        r_valid_o;
   logic        r_ready_i;
   logic [63:0] r_data_o;
   logic [1:0]  r_resp_o;
   logic        aw_valid_i;
   logic        aw_ready_o;
   logic        w_valid_i;
   logic        w_ready_o;
   logic        b_valid_o;
   logic        b_ready_i;
   logic [1:0]  b_resp_o;

   modport slave (
      input  ar_valid_i, ar_addr_i, r_ready_i,
      input  aw_valid_i, w_valid_i, b_ready_i,
      output ar_ready_o, r_valid_o, r_data_o, r_resp_o,
      output aw_ready_o, w_ready_o, b_valid_o, b_resp_o
   );

   modport master (
      output ar_valid_i, ar_addr_i, r_ready_i,
      output aw_valid_i, w_valid_i, b_ready_i,
      input  ar_ready_o, r_valid_o, r_data_o, r_resp_o,
      input  aw_ready_o, w_ready_o, b_valid_o, b_resp_o
   );
endinterface

// File: rtl/bootrom_axil_frontend.sv
// Read-only AXI4-Lite slave for the boot ROM: one read in flight,
// fixed-latency ROM access, writes always answered with SLVERR.
module bootrom_axil_frontend #(
   parameter logic [63:0] ROM_BASE    = 64'h0001_0000,
   parameter int unsigned ROM_SIZE    = 8192,
   parameter int unsigned ROM_LATENCY = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   bootrom_axil_frontend_if.slave axil,
   output logic                 rom_req_o,
   output logic [63:0]          rom_addr_o,
   input  logic [63:0]          rom_rdata_i
);
   typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} rstate_t;
   typedef enum logic {W_IDLE, W_RESP} wstate_t;

   localparam logic [63:0] SIZE   = 64'(ROM_SIZE);
   localparam logic [2:0]  LAT_M1 = 3'(ROM_LATENCY - 1);

   rstate_t     rstate;
   wstate_t     wstate;
   logic [2:0]  cnt;
   logic [63:0] offset;
   logic        in_win;
   logic        aw_done;
   logic        w_done;
   logic        aw_hs;
   logic        w_hs;
   logic        aw_got;
   logic        w_got;

   // Offset is only trusted once the lower bound holds, so no wrap.
   assign offset = axil.ar_addr_i - ROM_BASE;
   assign in_win = (axil.ar_addr_i >= ROM_BASE) && (offset < SIZE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rstate          <= R_IDLE;
         cnt             <= '0;
         axil.ar_ready_o <= 1'b1;
         axil.r_valid_o  <= 1'b0;
         axil.r_data_o   <= '0;
         axil.r_resp_o   <= '0;
         rom_req_o       <= 1'b0;
         rom_addr_o      <= '0;
      end else begin
         unique case (rstate)
            R_IDLE: begin
               if (axil.ar_valid_i) begin
                  axil.ar_ready_o <= 1'b0;
                  if (in_win) begin
                     rom_req_o  <= 1'b1;
                     rom_addr_o <= {offset[63:3], 3'b000};
                     rstate     <= R_REQ;
                  end else begin
                     axil.r_valid_o <= 1'b1;
                     axil.r_data_o  <= '0;
                     axil.r_resp_o  <= 2'b11;
                     rstate         <= R_RESP;
                  end
               end
            end
            R_REQ: begin
               rom_req_o <= 1'b0;
               cnt       <= LAT_M1;
               rstate    <= R_WAIT;
            end
            R_WAIT: begin
               if (cnt == 3'd0) begin
                  axil.r_valid_o <= 1'b1;
                  axil.r_data_o  <= rom_rdata_i;
                  axil.r_resp_o  <= 2'b00;
                  rstate         <= R_RESP;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            R_RESP: begin
               if (axil.r_ready_i) begin
                  axil.r_valid_o  <= 1'b0;
                  axil.ar_ready_o <= 1'b1;
                  rstate          <= R_IDLE;
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

   assign aw_hs  = axil.aw_valid_i && axil.aw_ready_o;
   assign w_hs   = axil.w_valid_i && axil.w_ready_o;
   assign aw_got = aw_done || aw_hs;
   assign w_got  = w_done || w_hs;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wstate          <= W_IDLE;
         aw_done         <= 1'b0;
         w_done          <= 1'b0;
         axil.aw_ready_o <= 1'b1;
         axil.w_ready_o  <= 1'b1;
         axil.b_valid_o  <= 1'b0;
         axil.b_resp_o   <= '0;
      end else begin
         unique case (wstate)
            W_IDLE: begin
               if (aw_got && w_got) begin
                  aw_done         <= 1'b1;
                  w_done          <= 1'b1;
                  axil.aw_ready_o <= 1'b0;
                  axil.w_ready_o  <= 1'b0;
                  axil.b_valid_o  <= 1'b1;
                  axil.b_resp_o   <= 2'b10;
                  wstate          <= W_RESP;
               end else begin
                  if (aw_hs) begin
                     aw_done         <= 1'b1;
                     axil.aw_ready_o <= 1'b0;
                  end
                  if (w_hs) begin
                     w_done         <= 1'b1;
                     axil.w_ready_o <= 1'b0;
                  end
               end
            end
            W_RESP: begin
               if (axil.b_ready_i) begin
                  aw_done         <= 1'b0;
                  w_done          <= 1'b0;
                  axil.aw_ready_o <= 1'b1;
                  axil.w_ready_o  <= 1'b1;
                  axil.b_valid_o  <= 1'b0;
                  wstate          <= W_IDLE;
               end
            end
            default: wstate <= W_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bootrom_axil_frontend.sv
// Scoreboard bench for the boot ROM AXI-Lite front-end (latency 1 and 3).
module tb_bootrom_axil_frontend;
   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk = ~clk;

   bootrom_axil_frontend_if if1 ();
   bootrom_axil_frontend_if if2 ();

   logic        req1, req2;
   logic [63:0] addr1, addr2, rd1, rd2;
   logic [7:0]  p1 = '0, p2 = '0;
   logic [63:0] a1 = '0, a2 = '0;

   bootrom_axil_frontend #(.ROM_LATENCY(1)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .axil(if1.slave),
      .rom_req_o(req1), .rom_addr_o(addr1), .rom_rdata_i(rd1));

   bootrom_axil_frontend #(.ROM_LATENCY(3)) dut3 (
      .clk_i(clk), .rst_ni(rst_ni), .axil(if2.slave),
      .rom_req_o(req2), .rom_addr_o(addr2), .rom_rdata_i(rd2));

   function automatic logic [63:0] romf(logic [63:0] a);
      if (a == 64'd8) return 64'hDEAD_BEEF_0123_4567;
      return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
   endfunction

   // ROM models: data valid only in the cycle ROM_LATENCY after the request.
   always @(posedge clk) begin
      p1 <= {p1[6:0], req1};
      p2 <= {p2[6:0], req2};
      if (req1) a1 <= addr1;
      if (req2) a2 <= addr2;
   end
   assign rd1 = p1[0] ? romf(a1) : 64'hBAD0_BAD0_BAD0_BAD0;
   assign rd2 = p2[2] ? romf(a2) : 64'hBAD0_BAD0_BAD0_BAD0;

   typedef struct packed {
      logic [63:0] d;
      logic [1:0]  r;
   } rexp_t;

   rexp_t      rq[$];
   logic [1:0] bq[$];
   int n_checks = 0;
   int n_err = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_ni && if1.r_valid_o && if1.r_ready_i) begin
         if (rq.size() == 0) begin
            check("r_unexpected", 64'd1, 64'd0);
         end else begin
            rexp_t e;
            e = rq.pop_front();
            check("r_data", if1.r_data_o, e.d);
            check("r_resp", 64'(if1.r_resp_o), 64'(e.r));
         end
      end
      if (rst_ni && if1.b_valid_o && if1.b_ready_i) begin
         if (bq.size() == 0) begin
            check("b_unexpected", 64'd1, 64'd0);
         end else begin
            logic [1:0] eb;
            eb = bq.pop_front();
            check("b_resp", 64'(if1.b_resp_o), 64'(eb));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_read(input logic [63:0] addr, input rexp_t e,
                             input bit push, output int wc,
                             output bit saw, output int rc,
                             output logic [63:0] ra, output int vc);
      int n;
      if1.ar_valid_i = 1'b1;
      if1.ar_addr_i  = addr;
      wc = 0;
      while (!if1.ar_ready_o && wc < 20) begin
         step();
         wc++;
      end
      if (push) rq.push_back(e);
      step();
      if1.ar_valid_i = 1'b0;
      n   = 1;
      saw = 1'b0;
      rc  = 0;
      ra  = '0;
      while (n <= 20) begin
         if (req1 && !saw) begin
            saw = 1'b1;
            rc  = n;
            ra  = addr1;
         end
         if (if1.r_valid_o) break;
         step();
         n++;
      end
      vc = n;
   endtask

   task automatic write_seq(input int mode);
      bq.push_back(2'b10);
      case (mode)
         0: begin
            if1.w_valid_i = 1'b1;
            step();
            if1.w_valid_i = 1'b0;
            step();
            if1.aw_valid_i = 1'b1;
            step();
            if1.aw_valid_i = 1'b0;
         end
         1: begin
            if1.aw_valid_i = 1'b1;
            if1.w_valid_i  = 1'b1;
            step();
            if1.aw_valid_i = 1'b0;
            if1.w_valid_i  = 1'b0;
         end
         default: begin
            if1.aw_valid_i = 1'b1;
            step();
            if1.aw_valid_i = 1'b0;
            if1.w_valid_i  = 1'b1;
            step();
            if1.w_valid_i  = 1'b0;
         end
      endcase
      check($sformatf("b_valid_m%0d", mode), 64'(if1.b_valid_o), 64'd1);
      step();
      check($sformatf("b_single_m%0d", mode), 64'(if1.b_valid_o), 64'd0);
   endtask

   logic [63:0] oow [3];
   logic [63:0] d0;
   int wc, rc, vc, n;
   bit saw;
   logic [63:0] ra;

   initial begin
      oow[0] = 64'h0000_0000_0000_FFF8;
      oow[1] = 64'h0000_0000_0001_2000;
      oow[2] = 64'hFFFF_FFFF_FFFF_FFF8;
      if1.ar_valid_i = 0; if1.ar_addr_i = '0; if1.r_ready_i = 1;
      if1.aw_valid_i = 0; if1.w_valid_i = 0; if1.b_ready_i = 1;
      if2.ar_valid_i = 0; if2.ar_addr_i = '0; if2.r_ready_i = 1;
      if2.aw_valid_i = 0; if2.w_valid_i = 0; if2.b_ready_i = 1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_flags", {58'd0, if1.ar_ready_o, if1.aw_ready_o,
            if1.w_ready_o, if1.r_valid_o, if1.b_valid_o, req1},
            64'b111000);
      check("rst_rdata", if1.r_data_o, 64'd0);
      check("rst_resps", {60'd0, if1.r_resp_o, if1.b_resp_o}, 64'd0);
      check("rst_romaddr", addr1, 64'd0);
      rst_ni = 1'b1;
      step();

      issue_read(64'h1_0008, '{64'hDEAD_BEEF_0123_4567, 2'b00}, 1,
                 wc, saw, rc, ra, vc);
      check("rd1_req_cycle", 64'(rc), 64'd1);
      check("rd1_rom_addr", ra, 64'd8);
      check("rd1_valid_cycle", 64'(vc), 64'd3);
      step();

      issue_read(64'h1_1FFD, '{romf(64'h1FF8), 2'b00}, 1,
                 wc, saw, rc, ra, vc);
      check("unal_rom_addr", ra, 64'h1FF8);
      step();

      for (int i = 0; i < 3; i++) begin
         issue_read(oow[i], '{64'd0, 2'b11}, 1, wc, saw, rc, ra, vc);
         check($sformatf("oow%0d_noreq", i), 64'(saw), 64'd0);
         check($sformatf("oow%0d_valid_cycle", i), 64'(vc), 64'd1);
         step();
      end

      if1.r_ready_i = 1'b0;
      issue_read(64'h1_0010, '{romf(64'h10), 2'b00}, 1,
                 wc, saw, rc, ra, vc);
      d0 = romf(64'h10);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid_arready", {62'd0, if1.r_valid_o, if1.ar_ready_o},
               64'b10);
         check("bp_data_stable", if1.r_data_o, d0);
         step();
      end
      if1.r_ready_i = 1'b1;
      step();
      check("b2b_arready", 64'(if1.ar_ready_o), 64'd1);
      issue_read(64'h1_0018, '{romf(64'h18), 2'b00}, 1,
                 wc, saw, rc, ra, vc);
      check("b2b_accept_wait", 64'(wc), 64'd0);
      step();

      for (int m = 0; m < 3; m++) begin
         write_seq(m);
         step();
      end

      fork
         issue_read(64'h1_0008, '{64'hDEAD_BEEF_0123_4567, 2'b00}, 1,
                    wc, saw, rc, ra, vc);
         write_seq(1);
      join
      check("conc_valid_cycle", 64'(vc), 64'd3);
      step();
      step();

      if1.ar_valid_i = 1'b1;
      if1.ar_addr_i  = 64'h1_0020;
      step();
      if1.ar_valid_i = 1'b0;
      step();
      rst_ni = 1'b0;
      #1;
      check("mid_rst_flags", {58'd0, if1.ar_ready_o, if1.aw_ready_o,
            if1.w_ready_o, if1.r_valid_o, if1.b_valid_o, req1},
            64'b111000);
      check("mid_rst_rdata", if1.r_data_o, 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         if (if1.r_valid_o) n++;
         step();
      end
      check("mid_rst_no_beat", 64'(n), 64'd0);

      if2.ar_valid_i = 1'b1;
      if2.ar_addr_i  = 64'h1_0008;
      step();
      if2.ar_valid_i = 1'b0;
      n = 1;
      while (!if2.r_valid_o && n < 20) begin
         step();
         n++;
      end
      check("lat3_valid_cycle", 64'(n), 64'd5);
      check("lat3_data", if2.r_data_o, 64'hDEAD_BEEF_0123_4567);
      check("lat3_resp", 64'(if2.r_resp_o), 64'd0);
      step();

      n = 0;
      while ((rq.size() != 0 || bq.size() != 0) && n < 20) begin
         step();
         n++;
      end
      check("rq_drained", 64'(rq.size()), 64'd0);
      check("bq_drained", 64'(bq.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
